// File: rtl/fios_res_collector_if.sv
// fios_res_collector_if: limb stream in, reduced-result handshake out, for the FIOS result collector
interface fios_res_collector_if #(parameter int s = 8);
  localparam int W = 17 * s;
  logic          res_valid_i;
  logic [16:0]   res_i;
  logic [W-1:0]  p_i;
  logic [W-1:0]  res_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          busy_o;
  logic          overrun_o;
  modport master (
    output res_valid_i, res_i, p_i, res_ready_i,
    input  res_o, res_valid_o, busy_o, overrun_o
  );
  modport slave (
    input  res_valid_i, res_i, p_i, res_ready_i,
    output res_o, res_valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/fios_res_collector.sv
// fios_res_collector: reassembles FIOS result limbs and applies the final conditional subtraction of p
module fios_res_collector #(parameter int s = 8) (
  input logic clock_i,
  input logic reset_i,
  fios_res_collector_if.slave bus
);
  localparam int W  = 17 * s;
  localparam int CW = s > 1 ? $clog2(s) : 1;
  typedef enum logic [1:0] {C, S, O} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, k_q, k_d;
  logic [W-1:0] acc_q, acc_d, diff_q, diff_d, res_q, res_d, fin;
  logic borrow_q, borrow_d, ovr_q, ovr_d, take, last_k;
  logic [17:0] sub;
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= C;
    else state_q <= state_d;
  end
  always_comb begin
    last_k  = k_q == CW'(s - 1);
    state_d = state_q == C ? (bus.res_valid_i && idx_q == CW'(s - 1) ? S : C) :
              state_q == S ? (last_k ? O : S) :
              (bus.res_ready_i ? C : O);
  end
  always_comb begin
    bus.res_valid_o = state_q == O;
    bus.busy_o      = state_q != C || idx_q != '0;
    bus.res_o       = res_q;
    bus.overrun_o   = ovr_q;
  end
  // One limb of acc - p per cycle; the top limb is spliced in unregistered so the select happens on the last cycle
  always_comb begin
    sub  = {1'b0, acc_q[17*k_q +: 17]} - {1'b0, bus.p_i[17*k_q +: 17]} - {17'd0, borrow_q};
    fin  = diff_q;
    fin[W-1 -: 17] = sub[16:0];
    take = state_q == C && bus.res_valid_i;
    idx_d = take ? (idx_q == CW'(s - 1) ? '0 : idx_q + 1'b1) : idx_q;
    acc_d = acc_q;
    if (take) acc_d[17*idx_q +: 17] = bus.res_i;
    diff_d = diff_q;
    if (state_q == S) diff_d[17*k_q +: 17] = sub[16:0];
    k_d      = state_q == S && !last_k ? k_q + 1'b1 : '0;
    borrow_d = state_q == S ? sub[17] : 1'b0;
    res_d    = state_q == S && last_k ? (sub[17] ? acc_q : fin) : res_q;
    ovr_d    = ovr_q | (bus.res_valid_i && state_q != C);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      idx_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule

// File: tb/tb_fios_res_collector.sv
// tb_fios_res_collector: randomized and directed checks of the result collector at s=2 and s=8
module tb_fios_res_collector;
  logic clk, rst;
  int n_chk, n_fail;
  fios_res_collector_if #(.s(2)) b2();
  fios_res_collector_if #(.s(8)) b8();
  fios_res_collector #(.s(2)) dut2 (.clock_i(clk), .reset_i(rst), .bus(b2.slave));
  fios_res_collector #(.s(8)) dut8 (.clock_i(clk), .reset_i(rst), .bus(b8.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [135:0] reduce(input logic [135:0] a, input logic [135:0] m);
    return a >= m ? a - m : a;
  endfunction
  task automatic send2(input logic [33:0] acc, input int gap);
    for (int i = 0; i < 2; i++) begin
      b2.res_i = acc[17*i +: 17];
      b2.res_valid_i = 1'b1;
      @(negedge clk);
      b2.res_valid_i = 1'b0;
      if (i == 0) repeat (gap) @(negedge clk);
    end
  endtask
  task automatic wait2(input int start, output int lat);
    lat = start;
    while (!b2.res_valid_o && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic send8(input logic [135:0] acc);
    for (int i = 0; i < 8; i++) begin
      b8.res_i = acc[17*i +: 17];
      b8.res_valid_i = 1'b1;
      @(negedge clk);
      b8.res_valid_i = 1'b0;
      if (i < 7) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  task automatic wait8(output int lat);
    lat = 1;
    while (!b8.res_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b2.res_o, b2.res_valid_o, b2.busy_o, b2.overrun_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_s2 got res=%h v=%b b=%b o=%b exp all 0", b2.res_o, b2.res_valid_o, b2.busy_o, b2.overrun_o);
    end
    n_chk++;
    if ({b8.res_o, b8.res_valid_o, b8.busy_o, b8.overrun_o} !== 139'd0) begin
      n_fail++;
      $display("FAIL reset_s8 got res=%h v=%b b=%b o=%b exp all 0", b8.res_o, b8.res_valid_o, b8.busy_o, b8.overrun_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_no_sub;
    int lat;
    b2.p_i = 34'd7;
    b2.res_ready_i = 1'b1;
    send2(34'd5, 0);
    wait2(1, lat);
    n_chk++;
    if (lat !== 3) begin n_fail++; $display("FAIL nosub_latency got %0d exp 3", lat); end
    n_chk++;
    if (b2.res_o !== 34'd5) begin n_fail++; $display("FAIL nosub_result got %h exp 5", b2.res_o); end
    @(negedge clk);
    n_chk++;
    if (b2.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL nosub_one_cycle got valid=%b exp 0", b2.res_valid_o); end
    n_chk++;
    if (b2.busy_o !== 1'b0) begin n_fail++; $display("FAIL nosub_busy_fall got %b exp 0", b2.busy_o); end
  endtask
  task automatic test_subtract;
    logic [33:0] acc [2];
    logic [33:0] exp [2];
    int lat;
    acc[0] = 34'd9; exp[0] = 34'd2;
    acc[1] = 34'd7; exp[1] = 34'd0;
    b2.p_i = 34'd7;
    for (int i = 0; i < 2; i++) begin
      send2(acc[i], 0);
      wait2(1, lat);
      n_chk++;
      if (b2.res_o !== exp[i] || b2.res_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL subtract_%0d got res=%h v=%b exp %h", i, b2.res_o, b2.res_valid_o, exp[i]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_borrow;
    int lat;
    b2.p_i = 34'h20001;
    send2(34'h40000, 0);
    wait2(1, lat);
    n_chk++;
    if (b2.res_o !== 34'h1FFFF) begin n_fail++; $display("FAIL cross_borrow got %h exp 1ffff", b2.res_o); end
    @(negedge clk);
  endtask
  task automatic test_gap_backpressure;
    int lat, xfers;
    b2.p_i = 34'd7;
    b2.res_ready_i = 1'b0;
    b2.res_i = 17'd9;
    b2.res_valid_i = 1'b1;
    @(negedge clk);
    b2.res_valid_i = 1'b0;
    n_chk++;
    if (b2.busy_o !== 1'b1) begin n_fail++; $display("FAIL gap_busy_rise got %b exp 1", b2.busy_o); end
    repeat (4) @(negedge clk);
    b2.res_i = 17'd0;
    b2.res_valid_i = 1'b1;
    @(negedge clk);
    b2.res_valid_i = 1'b0;
    wait2(1, lat);
    n_chk++;
    if (lat !== 3) begin n_fail++; $display("FAIL gap_latency got %0d exp 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (b2.res_valid_o !== 1'b1 || b2.res_o !== 34'd2) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d got res=%h v=%b exp 2 v=1", i, b2.res_o, b2.res_valid_o);
      end
    end
    b2.res_ready_i = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (b2.res_valid_o && b2.res_ready_i) xfers++;
      @(negedge clk);
    end
    n_chk++;
    if (xfers !== 1) begin n_fail++; $display("FAIL backpressure_transfers got %0d exp 1", xfers); end
  endtask
  task automatic test_back_to_back;
    int lat;
    b2.p_i = 34'd7;
    send2(34'd9, 0);
    wait2(1, lat);
    n_chk++;
    if (b2.res_o !== 34'd2) begin n_fail++; $display("FAIL b2b_first got %h exp 2", b2.res_o); end
    @(negedge clk);
    send2(34'd12, 0);
    wait2(1, lat);
    n_chk++;
    if (b2.res_o !== 34'd5 || lat !== 3) begin n_fail++; $display("FAIL b2b_second got %h lat %0d exp 5 lat 3", b2.res_o, lat); end
    n_chk++;
    if (b2.overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun got %b exp 0", b2.overrun_o); end
    @(negedge clk);
  endtask
  task automatic test_overrun;
    int lat;
    b2.p_i = 34'd7;
    send2(34'd9, 0);
    b2.res_i = 17'h1ABCD;
    b2.res_valid_i = 1'b1;
    @(negedge clk);
    b2.res_valid_i = 1'b0;
    n_chk++;
    if (b2.overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b exp 1", b2.overrun_o); end
    wait2(2, lat);
    n_chk++;
    if (b2.res_o !== 34'd2 || lat !== 3) begin n_fail++; $display("FAIL overrun_result got %h lat %0d exp 2 lat 3", b2.res_o, lat); end
    @(negedge clk);
    n_chk++;
    if (b2.overrun_o !== 1'b1 || b2.res_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_sticky got o=%b v=%b exp o=1 v=0", b2.overrun_o, b2.res_valid_o);
    end
  endtask
  task automatic test_reset_mid;
    int lat;
    b2.p_i = 34'd7;
    b2.res_i = 17'd3;
    b2.res_valid_i = 1'b1;
    @(negedge clk);
    b2.res_valid_i = 1'b0;
    n_chk++;
    if (b2.busy_o !== 1'b1) begin n_fail++; $display("FAIL midreset_busy got %b exp 1", b2.busy_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({b2.res_o, b2.res_valid_o, b2.busy_o, b2.overrun_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL midreset_clear got res=%h v=%b b=%b o=%b exp all 0", b2.res_o, b2.res_valid_o, b2.busy_o, b2.overrun_o);
    end
    send2(34'd9, 0);
    wait2(1, lat);
    n_chk++;
    if (b2.res_o !== 34'd2) begin n_fail++; $display("FAIL midreset_after got %h exp 2", b2.res_o); end
    @(negedge clk);
  endtask
  task automatic test_random_s2;
    logic [135:0] p, a, e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      p = '0;
      p[31:0] = $urandom;
      p[32] = 1'($urandom_range(0, 1));
      if (p == 0) p = 136'd1;
      a = '0;
      a[63:0] = {$urandom, $urandom};
      a = i == 0 ? p : i == 1 ? (p << 1) - 136'd1 : a % (p << 1);
      e = reduce(a, p);
      b2.p_i = p[33:0];
      send2(a[33:0], $urandom_range(0, 3));
      wait2(1, lat);
      n_chk++;
      if (b2.res_o !== e[33:0] || lat !== 3) begin
        n_fail++;
        $display("FAIL random_s2_%0d got %h lat %0d exp %h lat 3", i, b2.res_o, lat, e[33:0]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_default_s8;
    logic [135:0] p, a, e;
    int lat;
    b8.res_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p[127:0] = {$urandom, $urandom, $urandom, $urandom};
      p[134:128] = 7'($urandom_range(0, 127));
      p[135] = 1'b0;
      if (p == 0) p = 136'd1;
      a[127:0] = {$urandom, $urandom, $urandom, $urandom};
      a[135:128] = 8'($urandom_range(0, 255));
      a = i == 0 ? p : i == 1 ? (p << 1) - 136'd1 : a % (p << 1);
      e = reduce(a, p);
      b8.p_i = p;
      send8(a);
      wait8(lat);
      n_chk++;
      if (b8.res_o !== e || lat !== 9) begin
        n_fail++;
        $display("FAIL default_s8_%0d got %h lat %0d exp %h lat 9", i, b8.res_o, lat, e);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    b2.res_valid_i = 1'b0; b2.res_i = '0; b2.p_i = '0; b2.res_ready_i = 1'b1;
    b8.res_valid_i = 1'b0; b8.res_i = '0; b8.p_i = '0; b8.res_ready_i = 1'b1;
    test_reset;
    test_no_sub;
    test_subtract;
    test_borrow;
    test_gap_backpressure;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_random_s2;
    test_default_s8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
